// File: rtl/rx_decap_fifo.sv
// rtl/rx_decap_fifo.sv - receive identifier decapsulation with show-ahead frame FIFO (optional ACCEPT_FILTER_EN)
module rx_decap_fifo #(
  parameter int DEPTH       = 4,
  parameter int DATA_BYTES  = 8,
  parameter int NUM_FILTERS = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [17:0]                    message_b,
  input  logic [10:0]                    message_c,
  input  logic                           extended,
  input  logic                           rtr_in,
  input  logic [3:0]                     dlc_in,
  input  logic [8*DATA_BYTES-1:0]        data_in,
  input  logic                           frame_valid,
  input  logic [29*NUM_FILTERS-1:0]      acc_code,
  input  logic [29*NUM_FILTERS-1:0]      acc_mask,
  input  logic [NUM_FILTERS-1:0]         acc_ext,
  input  logic                           rx_pop,
  input  logic                           ovr_clr,
  output logic [28:0]                    rx_id,
  output logic                           rx_ext,
  output logic                           rx_rtr,
  output logic [3:0]                     rx_dlc,
  output logic [8*DATA_BYTES-1:0]        rx_data,
  output logic [2:0]                     rx_hit,
  output logic                           rx_avail,
  output logic [$clog2(DEPTH+1)-1:0]     rx_count,
  output logic                           rx_overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int DW = 8 * DATA_BYTES;

  typedef struct packed {
    logic [28:0]   id;
    logic          ext;
    logic          rtr;
    logic [3:0]    dlc;
    logic [DW-1:0] data;
    logic [2:0]    hit;
  } entry_t;

  logic [28:0]   asm_id;
  logic [DW-1:0] norm_data;
  logic          accept;
  logic [2:0]    hit;

  logic          s1_valid;
  entry_t        s1_entry;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          do_pop;
  logic          do_write;
  logic          ovf_event;

  // Build the 29-bit identifier from the shift-register fields.
  always_comb begin
    asm_id = 29'd0;
    if (extended) begin
      asm_id = {message_c, message_b};
    end else begin
      asm_id = {message_b[10:0], 18'd0};
    end
  end

  // Zero bytes beyond the effective length; remote frames carry no data.
  always_comb begin
    norm_data = '0;
    for (int b = 0; b < DATA_BYTES; b++) begin
      if (!rtr_in && (int'(dlc_in) > b)) begin
        norm_data[8*b +: 8] = data_in[8*b +: 8];
      end
    end
  end

`ifdef ACCEPT_FILTER_EN
  // Acceptance filtering; scanning downwards leaves the lowest matching index.
  always_comb begin
    accept = 1'b0;
    hit    = 3'd0;
    for (int k = NUM_FILTERS - 1; k >= 0; k--) begin
      if ((((asm_id ^ acc_code[29*k +: 29]) & ~acc_mask[29*k +: 29]) == 29'd0) &&
          (acc_ext[k] == extended)) begin
        accept = 1'b1;
        hit    = 3'(k);
      end
    end
  end
`else
  logic unused_acc;
  assign unused_acc = ^{acc_code, acc_mask, acc_ext};
  assign accept     = 1'b1;
  assign hit        = 3'd0;
`endif

  // Stage 1: capture the decoded frame; rejected frames never become valid.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_entry <= '0;
    end else begin
      s1_valid <= frame_valid && accept;
      if (frame_valid) begin
        s1_entry.id   <= asm_id;
        s1_entry.ext  <= extended;
        s1_entry.rtr  <= rtr_in;
        s1_entry.dlc  <= dlc_in;
        s1_entry.data <= norm_data;
        s1_entry.hit  <= hit;
      end
    end
  end

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign do_pop    = rx_pop && !empty;
  // A pop in the same cycle frees the slot the write needs.
  assign do_write  = s1_valid && (!full || do_pop);
  assign ovf_event = s1_valid && full && !rx_pop;

  // Stage 2: FIFO storage write.
  always_ff @(posedge clock) begin
    if (!reset && do_write) begin
      mem[wr_ptr] <= s1_entry;
    end
  end

  // Pointer, occupancy and sticky overflow bookkeeping.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      rx_overflow <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({do_write, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (ovf_event) begin
        rx_overflow <= 1'b1;
      end else if (ovr_clr) begin
        rx_overflow <= 1'b0;
      end
    end
  end

  assign head = mem[rd_ptr];

  // Show-ahead head view, forced to zero while the FIFO is empty.
  always_comb begin
    rx_id   = 29'd0;
    rx_ext  = 1'b0;
    rx_rtr  = 1'b0;
    rx_dlc  = 4'd0;
    rx_data = '0;
    rx_hit  = 3'd0;
    if (!empty) begin
      rx_id   = head.id;
      rx_ext  = head.ext;
      rx_rtr  = head.rtr;
      rx_dlc  = head.dlc;
      rx_data = head.data;
      rx_hit  = head.hit;
    end
  end

  assign rx_avail = !empty;
  assign rx_count = count;

endmodule
